// File: rtl/pwm_fader.sv
// pwm_fader: bus-programmed duty ramp/breathe sequencer driving pwm register writes
// Ports: clk, resetn (async active-low); CPU bus sel/wstrb/addr/wdata -> rdata;
//        pwm_wstrb/pwm_sel/pwm_wdata form a one-cycle duty write into pwm.
module pwm_fader #(
    parameter int DUTY_W  = 4,
    parameter int PRESC_W = 24
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sel,
    input  logic        wstrb,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        pwm_wstrb,
    output logic        pwm_sel,
    output logic [31:0] pwm_wdata
);
    typedef enum logic [1:0] {IDLE, COUNT, PUSH} state_t;

    state_t              state, state_nx;
    logic                en, breathe, dir, dir_nx;
    logic [DUTY_W-1:0]   target, cur, cur_nx, goal;
    logic [PRESC_W-1:0]  period, cnt, cnt_nx;
    logic                wr, bounce;

    assign wr     = sel & wstrb;
    assign goal   = (breathe && !dir) ? '0 : target;
    assign bounce = breathe && (target != '0);

    assign rdata = (addr == 2'd0) ? {30'b0, breathe, en} :
                   (addr == 2'd1) ? 32'(target) :
                   (addr == 2'd2) ? 32'(period) : 32'(cur);

    // cur only changes on edges that enter PUSH, so it doubles as the held duty
    assign pwm_wstrb = (state == PUSH);
    assign pwm_sel   = (state == PUSH);
    assign pwm_wdata = 32'(cur);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cur_nx   = cur;
        dir_nx   = dir;
        case (state)
            IDLE: begin
                if (en && (cur != goal || bounce)) begin
                    state_nx = COUNT;
                    cnt_nx   = '0;
                end
            end
            COUNT: begin
                if (!en) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == period) begin
                    state_nx = PUSH;
                    cnt_nx   = '0;
                    cur_nx   = (cur < goal) ? cur + 1'b1 : (cur > goal) ? cur - 1'b1 : cur;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            PUSH: begin
                cnt_nx = '0;
                if (!en) begin
                    state_nx = IDLE;
                end else if (cur != goal) begin
                    state_nx = COUNT;
                end else if (bounce) begin
                    state_nx = COUNT;
                    dir_nx   = !dir;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (wr && addr == 2'd0) begin
            dir_nx = 1'b1;
            if (!wdata[0]) begin
                state_nx = IDLE;
                cnt_nx   = '0;
                cur_nx   = cur;
            end
        end
        // a forced duty always gets pushed and wins over a same-edge step
        if (wr && addr == 2'd3) begin
            cur_nx   = wdata[DUTY_W-1:0];
            cnt_nx   = '0;
            state_nx = PUSH;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            cur     <= '0;
            dir     <= 1'b1;
            en      <= 1'b0;
            breathe <= 1'b0;
            target  <= '0;
            period  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            cur   <= cur_nx;
            dir   <= dir_nx;
            if (wr && addr == 2'd0) {breathe, en} <= wdata[1:0];
            if (wr && addr == 2'd1) target <= wdata[DUTY_W-1:0];
            if (wr && addr == 2'd2) period <= wdata[PRESC_W-1:0];
        end
    end
endmodule

// File: tb/tb_pwm_fader.sv
// tb_pwm_fader: scoreboard bench for pwm_fader push timing, values and register reads
module tb_pwm_fader;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sel = 1'b0, wstrb = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata, pwm_wdata;
    logic        pwm_wstrb, pwm_sel;

    typedef struct {int c; int v;} exp_t;
    exp_t sb[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    pwm_fader dut (
        .clk(clk), .resetn(resetn), .sel(sel), .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .rdata(rdata), .pwm_wstrb(pwm_wstrb), .pwm_sel(pwm_sel), .pwm_wdata(pwm_wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // each push is expected at a given cycle count (edge index) with a given duty
    always @(negedge clk) begin
        if (resetn) begin
            while (sb.size() > 0 && sb[0].c < cyc) begin
                compared++;
                mismatched++;
                $display("FAIL missed_push: no push seen at cyc %0d, required duty %0d", sb[0].c, sb[0].v);
                void'(sb.pop_front());
            end
            if (pwm_wstrb || pwm_sel) begin
                compared++;
                if (pwm_sel !== pwm_wstrb) begin
                    mismatched++;
                    $display("FAIL sel_eq_wstrb: sel=%b wstrb=%b at cyc %0d", pwm_sel, pwm_wstrb, cyc);
                end
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_push: duty %0d at cyc %0d, none required", pwm_wdata, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.c !== cyc || pwm_wdata !== 32'(e.v)) begin
                        mismatched++;
                        $display("FAIL push: got duty %0d at cyc %0d, required duty %0d at cyc %0d",
                                 pwm_wdata, cyc, e.v, e.c);
                    end
                end
            end
        end
    end

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input int d, output int acc);
        sel = 1'b1; wstrb = 1'b1; addr = a; wdata = 32'(d);
        ticks(1);
        acc = cyc;
        sel = 1'b0; wstrb = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0; sel = 1'b0; wstrb = 1'b0;
        ticks(2);
        resetn = 1'b1;
        ticks(1);
    endtask

    task automatic push_exp(input int c, input int v);
        exp_t e;
        e.c = c; e.v = v;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        do_reset();
        compared++;
        if (pwm_wstrb !== 1'b0 || pwm_sel !== 1'b0 || pwm_wdata !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_out: wstrb=%b sel=%b wdata=%0d, required 0/0/0", pwm_wstrb, pwm_sel, pwm_wdata);
        end
        for (int i = 0; i < 4; i++) begin
            addr = 2'(i);
            #1;
            compared++;
            if (rdata !== 32'd0) begin
                mismatched++;
                $display("FAIL reset_reg%0d: got %0d required 0", i, rdata);
            end
        end
        ticks(10);
    endtask

    task automatic test_ramp_up();
        int a;
        wr(2'd2, 3, a);
        wr(2'd1, 5, a);
        wr(2'd0, 1, a);
        for (int k = 1; k <= 5; k++) push_exp(a + 5 * k, k);
        ticks(40);
        compared++;
        if (sb.size() !== 0) begin
            mismatched++;
            $display("FAIL ramp_up_drain: %0d pushes outstanding, required 0", sb.size());
        end
        addr = 2'd3;
        #1;
        compared++;
        if (rdata !== 32'd5) begin
            mismatched++;
            $display("FAIL ramp_up_cur: got %0d required 5", rdata);
        end
    endtask

    task automatic test_retarget_and_cur();
        int a;
        wr(2'd1, 2, a);
        for (int k = 1; k <= 3; k++) push_exp(a + 5 * k, 5 - k);
        ticks(25);
        compared++;
        if (sb.size() !== 0) begin
            mismatched++;
            $display("FAIL retarget_drain: %0d pushes outstanding, required 0", sb.size());
        end
        wr(2'd3, 9, a);
        push_exp(a, 9);
        for (int v = 8; v >= 2; v--) push_exp(a + 5 * (9 - v), v);
        ticks(50);
        compared++;
        if (sb.size() !== 0) begin
            mismatched++;
            $display("FAIL cur_write_drain: %0d pushes outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_breathe();
        int a;
        int pat[6] = '{1, 2, 3, 2, 1, 0};
        do_reset();
        wr(2'd1, 3, a);
        wr(2'd2, 0, a);
        wr(2'd0, 3, a);
        for (int k = 1; k <= 14; k++) push_exp(a + 2 * k, pat[(k - 1) % 6]);
        ticks(28);
        wr(2'd0, 0, a);
        ticks(10);
        compared++;
        if (sb.size() !== 0) begin
            mismatched++;
            $display("FAIL breathe_drain: %0d pushes outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_en_clear();
        int a;
        do_reset();
        wr(2'd2, 3, a);
        wr(2'd1, 5, a);
        wr(2'd0, 1, a);
        push_exp(a + 5, 1);
        push_exp(a + 10, 2);
        ticks(11);
        wr(2'd0, 0, a);
        ticks(20);
        addr = 2'd3;
        #1;
        compared++;
        if (rdata !== 32'd2) begin
            mismatched++;
            $display("FAIL en_clear_hold: cur %0d required 2", rdata);
        end
        compared++;
        if (sb.size() !== 0) begin
            mismatched++;
            $display("FAIL en_clear_drain: %0d pushes outstanding, required 0", sb.size());
        end
        wr(2'd0, 1, a);
        for (int k = 1; k <= 3; k++) push_exp(a + 5 * k, 2 + k);
        ticks(25);
        compared++;
        if (sb.size() !== 0) begin
            mismatched++;
            $display("FAIL reenable_drain: %0d pushes outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_saturate();
        int a;
        do_reset();
        wr(2'd2, 0, a);
        wr(2'd1, 15, a);
        wr(2'd0, 1, a);
        for (int k = 1; k <= 15; k++) push_exp(a + 2 * k, k);
        ticks(50);
        compared++;
        if (sb.size() !== 0) begin
            mismatched++;
            $display("FAIL saturate_drain: %0d pushes outstanding, required 0", sb.size());
        end
        addr = 2'd3;
        #1;
        compared++;
        if (rdata !== 32'd15 || pwm_wdata !== 32'd15) begin
            mismatched++;
            $display("FAIL saturate_cur: cur %0d wdata %0d required 15", rdata, pwm_wdata);
        end
        addr = 2'd0;
        #1;
        compared++;
        if (rdata !== 32'd1) begin
            mismatched++;
            $display("FAIL ctrl_read: got %0d required 1", rdata);
        end
    endtask

    task automatic test_back_to_back();
        int a;
        do_reset();
        wr(2'd3, 7, a);
        push_exp(a, 7);
        wr(2'd3, 3, a);
        push_exp(a, 3);
        ticks(15);
        compared++;
        if (sb.size() !== 0) begin
            mismatched++;
            $display("FAIL b2b_drain: %0d pushes outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_ramp();
        int a;
        do_reset();
        wr(2'd2, 3, a);
        wr(2'd1, 5, a);
        wr(2'd0, 1, a);
        push_exp(a + 5, 1);
        ticks(10);
        compared++;
        if (pwm_wstrb !== 1'b1 || pwm_wdata !== 32'd2) begin
            mismatched++;
            $display("FAIL pre_reset_push: wstrb=%b wdata=%0d required 1/2", pwm_wstrb, pwm_wdata);
        end
        resetn = 1'b0;
        #1;
        compared++;
        if (pwm_wstrb !== 1'b0 || pwm_sel !== 1'b0 || pwm_wdata !== 32'd0) begin
            mismatched++;
            $display("FAIL async_reset: wstrb=%b sel=%b wdata=%0d required 0/0/0", pwm_wstrb, pwm_sel, pwm_wdata);
        end
        ticks(3);
        resetn = 1'b1;
        ticks(30);
        addr = 2'd3;
        #1;
        compared++;
        if (rdata !== 32'd0 || sb.size() !== 0) begin
            mismatched++;
            $display("FAIL post_reset: cur %0d outstanding %0d required 0/0", rdata, sb.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ramp_up();
        test_retarget_and_cur();
        test_breathe();
        test_en_clear();
        test_saturate();
        test_back_to_back();
        test_reset_mid_ramp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
